// File: rtl/dab_param_sequencer_pkg.sv
// Shared types, limits and the phase-step helper for the DAB parameter sequencer.
package dab_param_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STOP  = 3'd3,
    ST_FAULT = 3'd4
  } seq_state_t;

  localparam int FS_MIN     = 500;
  localparam int FS_MAX     = 250000;
  localparam int DT_MIN     = 1;
  localparam int PHI_MAX    = 255;
  localparam int FS_DEFAULT = 100000;
  localparam int DT_DEFAULT = 20;

  // One complete modulator parameter set.
  typedef struct packed {
    logic signed [8:0]  t1;
    logic signed [8:0]  t2;
    logic signed [8:0]  phi;
    logic signed [18:0] fs;
    logic [7:0]         dt;
  } param_set_t;

  // Move cur toward tgt by at most step; 10-bit signed so the difference of
  // two 9-bit phases never wraps, and the result lands exactly on tgt.
  function automatic logic signed [8:0] phi_step(
    input logic signed [8:0] cur,
    input logic signed [8:0] tgt,
    input int                step
  );
    logic signed [9:0] w_cur;
    logic signed [9:0] w_tgt;
    logic signed [9:0] w_diff;
    logic signed [9:0] w_stp;
    logic signed [9:0] w_next;
    w_cur  = {cur[8], cur};
    w_tgt  = {tgt[8], tgt};
    w_diff = w_tgt - w_cur;
    w_stp  = 10'(step);
    if (w_diff > w_stp)       w_next = w_cur + w_stp;
    else if (w_diff < -w_stp) w_next = w_cur - w_stp;
    else                      w_next = w_tgt;
    return w_next[8:0];
  endfunction

endpackage

// File: rtl/dab_param_sequencer_if.sv
// Host configuration channel. A set transfers on a clock edge where
// cfg_valid and cfg_ready are both high; the host holds data stable while
// cfg_valid is high and cfg_ready is low, and ready never depends on valid.
interface dab_param_sequencer_if;
  logic               cfg_valid;
  logic               cfg_ready;
  logic signed [8:0]  cfg_t1;
  logic signed [8:0]  cfg_t2;
  logic signed [8:0]  cfg_phi;
  logic signed [18:0] cfg_fs;
  logic [7:0]         cfg_dt;

  modport master (
    output cfg_valid, cfg_t1, cfg_t2, cfg_phi, cfg_fs, cfg_dt,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_t1, cfg_t2, cfg_phi, cfg_fs, cfg_dt,
    output cfg_ready
  );
endinterface

// File: rtl/dab_param_clamp.sv
// Combinational clamp of an offered parameter set into the safe operating range.
module dab_param_clamp
  import dab_param_sequencer_pkg::*;
(
  input  param_set_t i_set,
  output param_set_t o_set,
  output logic       o_sat
);

  localparam logic signed [9:0]  PHI_HI = 10'(PHI_MAX);
  localparam logic signed [9:0]  PHI_LO = -PHI_HI;
  localparam logic signed [10:0] LIM_HI = 11'(PHI_MAX);

  logic signed [10:0] w_limit_raw;
  logic signed [9:0]  w_limit;
  logic signed [9:0]  w_phi;
  logic               w_phi_clamp;
  logic               w_fs_clamp;
  logic               w_dt_clamp;

  // Phase upper bound follows the pulse widths; fs and dt get fixed bounds.
  always_comb begin
    o_set       = i_set;
    w_limit_raw = {{2{i_set.t2[8]}}, i_set.t2} - {{2{i_set.t1[8]}}, i_set.t1} + LIM_HI;
    w_limit     = (w_limit_raw > LIM_HI) ? PHI_HI : w_limit_raw[9:0];
    w_phi       = {i_set.phi[8], i_set.phi};
    w_phi_clamp = 1'b0;
    if (w_phi > w_limit) begin
      w_phi       = w_limit;
      w_phi_clamp = 1'b1;
    end
    if (w_phi < PHI_LO) begin
      w_phi       = PHI_LO;
      w_phi_clamp = 1'b1;
    end
    o_set.phi  = w_phi[8:0];
    w_fs_clamp = 1'b1;
    if ($signed(i_set.fs) < FS_MIN)      o_set.fs = 19'(FS_MIN);
    else if ($signed(i_set.fs) > FS_MAX) o_set.fs = 19'(FS_MAX);
    else                                 w_fs_clamp = 1'b0;
    w_dt_clamp = (i_set.dt < 8'(DT_MIN));
    if (w_dt_clamp) o_set.dt = 8'(DT_MIN);
    o_sat = w_phi_clamp | w_fs_clamp | w_dt_clamp;
  end

endmodule

// File: rtl/dab_param_sequencer.sv
// Applies host parameter sets to a DAB modulator on period boundaries,
// ramping the phase shift and supervising the modulator trigger.
module dab_param_sequencer
  import dab_param_sequencer_pkg::*;
#(
  parameter int PHI_STEP     = 4,
  parameter int TRIG_TIMEOUT = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 trigger,
  dab_param_sequencer_if.slave cfg,
  output logic signed [8:0]    t1_o,
  output logic signed [8:0]    t2_o,
  output logic signed [8:0]    phi_o,
  output logic signed [18:0]   fs_o,
  output logic [7:0]           dt_o,
  output logic                 run,
  output logic                 sat,
  output logic                 fault,
  output seq_state_t           dbg_state_o
);

  localparam int               CNT_W   = $clog2(TRIG_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TRIG_TIMEOUT);
  localparam param_set_t       RESET_SET = '{t1: 9'sd0, t2: 9'sd0, phi: 9'sd0,
                                             fs: 19'(FS_DEFAULT), dt: 8'(DT_DEFAULT)};

  seq_state_t         r_state;
  logic               r_trig_q;
  logic               r_live;
  logic               r_pending;
  param_set_t         r_tgt;
  logic signed [8:0]  r_t1, r_t2, r_phi;
  logic signed [18:0] r_fs;
  logic [7:0]         r_dt;
  logic               r_run, r_sat, r_fault;
  logic [CNT_W-1:0]   r_cnt;

  param_set_t         w_raw_set;
  param_set_t         w_clamped;
  logic               w_clamp_sat;
  logic               w_trig_rise;
  logic               w_ready;
  logic               w_accept;
  logic               w_timeout;
  logic signed [8:0]  w_phi_ramp;
  logic signed [8:0]  w_phi_stop;

  assign w_raw_set = '{t1: cfg.cfg_t1, t2: cfg.cfg_t2, phi: cfg.cfg_phi,
                       fs: cfg.cfg_fs, dt: cfg.cfg_dt};

  dab_param_clamp u_clamp (
    .i_set (w_raw_set),
    .o_set (w_clamped),
    .o_sat (w_clamp_sat)
  );

  // r_live keeps ready low until the first edge after reset releases.
  assign w_trig_rise   = trigger & ~r_trig_q;
  assign w_ready       = r_live && ((r_state == ST_IDLE) || (r_state == ST_RUN)) && !r_pending;
  assign cfg.cfg_ready = w_ready;
  assign w_accept      = cfg.cfg_valid && w_ready;
  assign w_timeout     = r_run && (r_cnt == CNT_MAX);
  assign w_phi_ramp    = phi_step(r_phi, r_tgt.phi, PHI_STEP);
  assign w_phi_stop    = phi_step(r_phi, 9'sd0, PHI_STEP);

  // Trigger history for edge detection and the post-reset live flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_q <= 1'b0;
      r_live   <= 1'b0;
    end else begin
      r_trig_q <= trigger;
      r_live   <= 1'b1;
    end
  end

  // Capture the clamped set and its saturation flag at acceptance only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt <= RESET_SET;
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_tgt <= w_clamped;
      r_sat <= w_clamp_sat;
    end
  end

  // Cycles since the last trigger rise while running; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (!r_run || w_trig_rise) r_cnt <= '0;
    else if (r_cnt != CNT_MAX)      r_cnt <= r_cnt + 1'b1;
  end

  // Sequencer FSM with registered modulator outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_t1      <= RESET_SET.t1;
      r_t2      <= RESET_SET.t2;
      r_phi     <= RESET_SET.phi;
      r_fs      <= RESET_SET.fs;
      r_dt      <= RESET_SET.dt;
      r_run     <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      // Ready is low whenever pending is set, so this never races a clear below.
      if (w_accept) r_pending <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (r_pending) begin
            r_t1 <= r_tgt.t1; r_t2 <= r_tgt.t2; r_fs <= r_tgt.fs; r_dt <= r_tgt.dt;
            r_pending <= 1'b0;
          end
          if (enable) begin
            r_state <= ST_RAMP;
            r_run   <= 1'b1;
          end
        end
        ST_RAMP: begin
          if (w_timeout) begin
            r_state <= ST_FAULT; r_run <= 1'b0; r_fault <= 1'b1; r_phi <= 9'sd0;
          end else if (!enable) begin
            r_state <= ST_STOP;
          end else if (w_trig_rise) begin
            if (r_pending) begin
              r_t1 <= r_tgt.t1; r_t2 <= r_tgt.t2; r_fs <= r_tgt.fs; r_dt <= r_tgt.dt;
              r_pending <= 1'b0;
            end
            r_phi <= w_phi_ramp;
            if (w_phi_ramp == r_tgt.phi) r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_timeout) begin
            r_state <= ST_FAULT; r_run <= 1'b0; r_fault <= 1'b1; r_phi <= 9'sd0;
          end else if (!enable) begin
            r_state <= ST_STOP;
          end else if (w_accept) begin
            // New set waits for the next period boundary inside RAMP.
            r_state <= ST_RAMP;
          end
        end
        ST_STOP: begin
          if (w_timeout) begin
            r_state <= ST_FAULT; r_run <= 1'b0; r_fault <= 1'b1; r_phi <= 9'sd0;
          end else if (enable) begin
            r_state <= ST_RAMP;
          end else if (r_phi == 9'sd0) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
          end else if (w_trig_rise) begin
            r_phi <= w_phi_stop;
          end
        end
        ST_FAULT: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign t1_o        = r_t1;
  assign t2_o        = r_t2;
  assign phi_o       = r_phi;
  assign fs_o        = r_fs;
  assign dt_o        = r_dt;
  assign run         = r_run;
  assign sat         = r_sat;
  assign fault       = r_fault;
  assign dbg_state_o = r_state;

endmodule
